lifo_rd_stream: RTL and testbench
=================================

Name: lifo_rd_stream

Overview:
- Read-side stage placed directly downstream of the LIFO pointer/RAM pair.
- Issues pop requests to the pointer logic whenever the stack is non-empty and there is local room.
- Captures the RAM read data, which arrives one cycle after an accepted pop.
- Presents the captured words on a valid/ready stream, in pop order, with full throughput and no data loss under backpressure.

Parameters:
- DWIDTH, 8, width of stack words and of the output stream.
- BUF_DEPTH, 2, number of output buffer entries. Must be at least 2.
- CWIDTH, $clog2(BUF_DEPTH+1), width of the occupancy counter. Derived; not overridden.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- arstn_i  in  1  asynchronous active-low reset.
- empty_i  in  1  empty flag from the pointer logic, registered there.
- wren_i  in  1  write enable from the pointer logic. When 1, the pointer logic gives the write priority and ignores rdreq that cycle.
- rdreq_o  out  1  pop request to the pointer logic.
- q_i  in  DWIDTH  RAM read data. Valid exactly one cycle after an accepted pop.
- data_o  out  DWIDTH  head-of-buffer data.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  downstream accepts data_o when valid_o && ready_i.
- buf_cnt_o  out  CWIDTH  number of words currently held in the buffer.

Behaviour:
- Reset:
  - Asynchronous on arstn_i low.
  - Clears occupancy, inflight, head and tail indices.
  - valid_o=0, buf_cnt_o=0, rdreq_o=0 while arstn_i is low.
  - data_o is don't-care while valid_o=0; buffer contents are not reset.
- Definitions:
  - pop_out = valid_o && ready_i.
  - pop_acc = rdreq_o && !empty_i && !wren_i. This is a pop actually taken by the pointer logic.
  - inflight: 1-bit register. inflight <= pop_acc.
- Issue rule:
  - rdreq_o = arstn_i && !empty_i && (occ + inflight - pop_out < BUF_DEPTH).
  - Combinational path from ready_i to rdreq_o is intentional; the downstream must not combinationally depend on rdreq_o.
  - rdreq_o may be high while wren_i=1. That cycle does not count as a pop, and inflight stays 0 next cycle.
- Capture:
  - When inflight=1, q_i is written at the tail index; tail advances modulo BUF_DEPTH.
  - The issue rule guarantees a free slot, so capture never overflows. Overflow is a design error; the bench asserts on it.
- Output:
  - valid_o = (occ != 0).
  - data_o = entry at the head index, driven combinationally from the buffer.
  - On pop_out, head advances modulo BUF_DEPTH.
- Occupancy:
  - occ_next = occ + inflight - pop_out.
  - Capture and pop_out in the same cycle leave occ unchanged but move both indices.
  - buf_cnt_o = occ.
- Ordering:
  - Words leave in the exact order they were popped, i.e. LIFO order relative to writes.
- Throughput:
  - With ready_i held 1 and the stack non-empty, one word per cycle after a 2-cycle startup: rdreq_o at cycle 0, capture at cycle 1, valid_o at cycle 2.
- Empty boundary:
  - empty_i is registered upstream, so a pop accepted in cycle N is reflected in empty_i at N+1.
  - No speculative pop past the last word is possible: if cycle N pops the last word, empty_i=1 at N+1 and rdreq_o=0.
- Backpressure:
  - With ready_i=0, at most BUF_DEPTH words are popped: occ + inflight reaches BUF_DEPTH, then rdreq_o drops.
  - valid_o and data_o hold stable until accepted.
- Reset mid-operation:
  - An in-flight word is discarded and buffered words are lost.
  - The pointer logic's state is independent; the system resets both together.

Test Plan:
- Reset: arstn_i=0 with empty_i=0 -> rdreq_o=0, valid_o=0, buf_cnt_o=0. After release, rdreq_o=1 in the first cycle.
- Streaming: stack holds 0x11,0x22,0x33 (0x33 on top), ready_i=1 -> data_o sequence 0x33,0x22,0x11 on consecutive cycles. First valid_o 2 cycles after first rdreq_o; exactly 3 pops; rdreq_o=0 once empty_i=1.
- Backpressure: 5 words stacked, ready_i=0 -> exactly 2 pops accepted, buf_cnt_o=2, valid_o stable with head 0x(top). Raise ready_i -> remaining 3 words follow without gaps or duplicates.
- Write collision: wren_i=1 in the cycle rdreq_o=1 -> no capture next cycle, buf_cnt_o unchanged. Pop retried on the next cycle, and the newly written word is delivered first.
- Simultaneous capture and drain: BUF_DEPTH=2, occ=2, ready_i toggling 1/0 each cycle with a steady stack -> no overflow assertion, head/tail wrap correctly, output equals popped-order reference model.
- Mid-run reset: arstn_i pulsed low while inflight=1 and occ=1 -> valid_o=0 immediately (asynchronous), buf_cnt_o=0, no stale word emitted after release.

Source files
------------

// File: rtl/lifo_rd_stream_if.sv
// Output word stream of the LIFO read stage.
// valid/ready handshake; a word moves when both are high.
interface lifo_rd_stream_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    output data_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/lifo_rd_stream.sv
// LIFO read stage: issues pops, captures RAM data one cycle later,
// and buffers the words onto a valid/ready stream in pop order.
module lifo_rd_stream #(
  parameter  int DWIDTH    = 8,
  parameter  int BUF_DEPTH = 2,
  localparam int CWIDTH    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                empty_i,
  input  logic                wren_i,
  output logic                rdreq_o,
  input  logic [DWIDTH-1:0]   q_i,
  lifo_rd_stream_if.master    st,
  output logic [CWIDTH-1:0]   buf_cnt_o
);

  localparam int IWIDTH = $clog2(BUF_DEPTH);
  localparam logic [IWIDTH-1:0] LAST =
    IWIDTH'(BUF_DEPTH - 1);
  localparam logic [CWIDTH:0] DEPTH =
    (CWIDTH + 1)'(BUF_DEPTH);

  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  logic [CWIDTH-1:0] occ_q;
  logic              inflight_q;
  logic [IWIDTH-1:0] head_q;
  logic [IWIDTH-1:0] tail_q;
  logic              pop_out;
  logic              pop_acc;
  logic [CWIDTH:0]   level;

  function automatic logic [IWIDTH-1:0] nxt(
    input logic [IWIDTH-1:0] i
  );
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  assign pop_out = st.valid_o && st.ready_i;

  // Next-cycle occupancy; also the room test for a new pop.
  assign level = {1'b0, occ_q}
               + {{CWIDTH{1'b0}}, inflight_q}
               - {{CWIDTH{1'b0}}, pop_out};

  assign rdreq_o = arstn_i && !empty_i
                && (level < DEPTH);
  assign pop_acc = rdreq_o && !empty_i && !wren_i;

  assign st.valid_o = (occ_q != '0);
  assign st.data_o  = mem[head_q];
  assign buf_cnt_o  = occ_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= level[CWIDTH-1:0];
      inflight_q <= pop_acc;
      if (inflight_q) tail_q <= nxt(tail_q);
      if (pop_out)    head_q <= nxt(head_q);
    end
  end

  // Storage is not reset; valid_o masks stale entries.
  always_ff @(posedge clk_i) begin
    if (inflight_q) mem[tail_q] <= q_i;
  end

endmodule

// File: tb/tb_lifo_rd_stream.sv
// Bench for lifo_rd_stream with a behavioural LIFO pointer/RAM
// and a pop-order scoreboard.
module tb_lifo_rd_stream;
  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = $clog2(BD + 1);

  logic          clk   = 1'b0;
  logic          arstn = 1'b0;
  logic          empty = 1'b1;
  logic          wren  = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] q     = '0;
  logic          rdreq;
  logic [CW-1:0] cnt;

  lifo_rd_stream_if #(.DWIDTH(DW)) st ();

  lifo_rd_stream #(.DWIDTH(DW), .BUF_DEPTH(BD)) dut (
    .clk_i    (clk),
    .arstn_i  (arstn),
    .empty_i  (empty),
    .wren_i   (wren),
    .rdreq_o  (rdreq),
    .q_i      (q),
    .st       (st),
    .buf_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int outs     = 0;
  int maxcnt   = 0;

  logic [DW-1:0] stk[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] w;

  logic          s_rdreq = 1'b0;
  logic          s_empty = 1'b1;
  logic          s_wren  = 1'b0;
  logic          s_pop   = 1'b0;
  logic [DW-1:0] s_wdata = '0;
  logic [DW-1:0] s_data  = '0;
  logic [CW-1:0] s_cnt   = '0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    s_rdreq = rdreq;
    s_empty = empty;
    s_wren  = wren;
    s_wdata = wdata;
    s_pop   = st.valid_o && st.ready_i;
    s_data  = st.data_o;
    s_cnt   = cnt;
    if (int'(cnt) > maxcnt) maxcnt = int'(cnt);
  end

  // Pointer/RAM model: write wins, pop data valid next cycle.
  always @(posedge clk) begin
    if (s_wren) begin
      stk.push_back(s_wdata);
    end else if (s_rdreq && !s_empty) begin
      w = stk.pop_back();
      q <= w;
      exp_q.push_back(w);
      pops++;
    end
    empty <= (stk.size() == 0);
    if (s_pop) begin
      outs++;
      if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
      else chk("sb_order", s_data, exp_q.pop_front());
    end
    chk("overflow", s_cnt <= BD, 1);
  end

  always @(negedge arstn) exp_q.delete();

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]    rd_pat;
    logic [5:0]    vl_pat;
    logic [DW-1:0] sd[6];
    int            p0;
    int            o0;

    rd_pat = 6'b000111;
    vl_pat = 6'b011100;
    sd     = '{8'h00, 8'h00, 8'h33, 8'h22, 8'h11, 8'h00};

    st.ready_i = 1'b1;
    stk.push_back(8'h11);
    stk.push_back(8'h22);
    stk.push_back(8'h33);
    step(3);
    chk("rst_empty_in", empty, 0);
    chk("rst_rdreq", rdreq, 0);
    chk("rst_valid", st.valid_o, 0);
    chk("rst_cnt", cnt, 0);

    // Streaming with ready held high
    arstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stream_rdreq%0d", i), rdreq, rd_pat[i]);
      chk($sformatf("stream_valid%0d", i),
          st.valid_o, vl_pat[i]);
      if (vl_pat[i])
        chk($sformatf("stream_data%0d", i), st.data_o, sd[i]);
    end
    chk("stream_pops", pops, 3);
    chk("stream_cnt", cnt, 0);

    // Backpressure
    step(1);
    st.ready_i = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 5; i++) stk.push_back(8'h40 + 8'(i));
    step(8);
    chk("bp_pops", pops - p0, 2);
    chk("bp_cnt", cnt, 2);
    chk("bp_valid", st.valid_o, 1);
    chk("bp_head", st.data_o, 8'h45);
    chk("bp_rdreq", rdreq, 0);
    step(3);
    chk("bp_hold", st.data_o, 8'h45);
    chk("bp_hold_pops", pops - p0, 2);
    o0 = outs;
    st.ready_i = 1'b1;
    step(5);
    chk("bp_burst", outs - o0, 5);
    chk("bp_total_pops", pops - p0, 5);
    chk("bp_done_valid", st.valid_o, 0);

    // Write collides with the first pop request
    stk.push_back(8'h51);
    step(1);
    wren  = 1'b1;
    wdata = 8'h52;
    p0    = pops;
    @(negedge clk);
    chk("col_rdreq", rdreq, 1);
    step(1);
    wren = 1'b0;
    @(negedge clk);
    chk("col_cnt", cnt, 0);
    chk("col_valid", st.valid_o, 0);
    chk("col_no_pop", pops - p0, 0);
    chk("col_retry", rdreq, 1);
    @(negedge clk);
    @(negedge clk);
    chk("col_first_valid", st.valid_o, 1);
    chk("col_first_data", st.data_o, 8'h52);
    step(3);
    chk("col_done_valid", st.valid_o, 0);
    chk("col_pops", pops - p0, 2);

    // Capture and drain together with toggling ready
    maxcnt = 0;
    for (int i = 0; i < 20; i++) stk.push_back(8'h60 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      st.ready_i = i[0];
      step(1);
    end
    st.ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (stk.size() == 0 && exp_q.size() == 0
          && !st.valid_o) break;
      step(1);
    end
    chk("wrap_drained",
        stk.size() == 0 && exp_q.size() == 0 && !st.valid_o, 1);
    chk("wrap_full_seen", maxcnt, 2);

    // Reset with one word held and one in flight
    st.ready_i = 1'b0;
    stk.push_back(8'h81);
    stk.push_back(8'h82);
    stk.push_back(8'h83);
    step(3);
    chk("mr_pre_cnt", cnt, 1);
    chk("mr_pre_valid", st.valid_o, 1);
    #1 arstn = 1'b0;
    #1;
    chk("mr_valid", st.valid_o, 0);
    chk("mr_cnt", cnt, 0);
    chk("mr_rdreq", rdreq, 0);
    step(2);
    arstn      = 1'b1;
    st.ready_i = 1'b1;
    @(negedge clk);
    chk("mr_no_stale0", st.valid_o, 0);
    @(negedge clk);
    chk("mr_no_stale1", st.valid_o, 0);
    @(negedge clk);
    chk("mr_next_valid", st.valid_o, 1);
    chk("mr_next_data", st.data_o, 8'h81);
    step(3);
    chk("mr_done_valid", st.valid_o, 0);
    chk("mr_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
